// File: rtl/pipe_pkg.sv
// Shared types for the RV32i inter-stage registers: skid FSM states,
// per-boundary widths and named-field structs for packing stage payloads.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } skid_state_t;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
        logic       mem_write;
        logic       jump;
        logic       branch;
        logic [2:0] alu_ctrl;
        logic       alu_src;
        logic [2:0] funct3;
        logic       pc_target_src;
        logic [1:0] spare;
    } idex_ctrl_t;

    typedef struct packed {
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] pc;
        logic [31:0] imm_ext;
        logic [31:0] pc_plus4;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
    } idex_data_t;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
        logic       mem_write;
        logic [2:0] funct3;
    } exmem_ctrl_t;

    typedef struct packed {
        logic [31:0] alu_result;
        logic [31:0] write_data;
        logic [31:0] pc_plus4;
        logic [4:0]  rd;
    } exmem_data_t;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
    } memwb_ctrl_t;

    typedef struct packed {
        logic [31:0] alu_result;
        logic [31:0] read_data;
        logic [31:0] pc_plus4;
        logic [4:0]  rd;
    } memwb_data_t;

    localparam int unsigned IDEX_CTRL_W  = $bits(idex_ctrl_t);
    localparam int unsigned IDEX_DATA_W  = $bits(idex_data_t);
    localparam int unsigned EXMEM_CTRL_W = $bits(exmem_ctrl_t);
    localparam int unsigned EXMEM_DATA_W = $bits(exmem_data_t);
    localparam int unsigned MEMWB_CTRL_W = $bits(memwb_ctrl_t);
    localparam int unsigned MEMWB_DATA_W = $bits(memwb_data_t);

endpackage

// File: rtl/pipe_skid_buf.sv
// Second-entry holding register and EMPTY/ONE/TWO state machine for the
// skid configuration; tells the parent when and from where to load its main register.
module pipe_skid_buf
    import pipe_pkg::*;
#(
    parameter int unsigned CTRL_W = 16,
    parameter int unsigned DATA_W = 165
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_fire,
    input  logic              out_fire,
    input  logic              flush,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              ready,
    output logic              main_load_in,
    output logic              main_load_skid,
    output logic              main_clear,
    output logic [CTRL_W-1:0] skid_ctrl,
    output logic [DATA_W-1:0] skid_data
);

    skid_state_t       state_q, state_d;
    logic              ready_q;
    logic              skid_load, skid_clear;
    logic [CTRL_W-1:0] skid_ctrl_q;
    logic [DATA_W-1:0] skid_data_q;

    always_comb begin
        state_d        = state_q;
        main_load_in   = 1'b0;
        main_load_skid = 1'b0;
        main_clear     = 1'b0;
        skid_load      = 1'b0;
        skid_clear     = 1'b0;
        if (flush) begin
            state_d    = EMPTY;
            skid_clear = 1'b1;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_d      = ONE;
                        main_load_in = 1'b1;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_load_in = 1'b1;
                    end else if (in_fire) begin
                        state_d   = TWO;
                        skid_load = 1'b1;
                    end else if (out_fire) begin
                        state_d    = EMPTY;
                        main_clear = 1'b1;
                    end
                end
                TWO: begin
                    // ready is low in TWO, so in_fire cannot occur here
                    if (out_fire) begin
                        state_d        = ONE;
                        main_load_skid = 1'b1;
                        skid_clear     = 1'b1;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= EMPTY;
            ready_q     <= 1'b0;
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d != TWO);
            if (skid_clear) begin
                skid_ctrl_q <= '0;
                skid_data_q <= '0;
            end else if (skid_load) begin
                skid_ctrl_q <= in_ctrl;
                skid_data_q <= in_data;
            end
        end
    end

    assign ready     = ready_q;
    assign skid_ctrl = skid_ctrl_q;
    assign skid_data = skid_data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register with ready/valid handshake, stall,
// flush and an optional two-entry skid buffer that registers in_ready.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned CTRL_W             = 16,
    parameter int unsigned DATA_W             = 165,
    parameter int unsigned SKID               = 0,
    parameter int unsigned ZERO_DATA_ON_FLUSH = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    input  logic              stall,
    input  logic              flush
);

    logic              in_fire, out_fire;
    logic              valid_q;
    logic [CTRL_W-1:0] ctrl_q;
    logic [DATA_W-1:0] data_q;
    logic              main_load_in, main_load_skid, main_clear;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;

    assign in_fire  = in_valid & in_ready & ~stall & ~flush;
    assign out_fire = valid_q & out_ready & ~stall;

    generate
        if (SKID != 0) begin : g_skid
            pipe_skid_buf #(
                .CTRL_W (CTRL_W),
                .DATA_W (DATA_W)
            ) u_skid (
                .clk            (clk),
                .rst            (rst),
                .in_fire        (in_fire),
                .out_fire       (out_fire),
                .flush          (flush),
                .in_ctrl        (in_ctrl),
                .in_data        (in_data),
                .ready          (in_ready),
                .main_load_in   (main_load_in),
                .main_load_skid (main_load_skid),
                .main_clear     (main_clear),
                .skid_ctrl      (skid_ctrl),
                .skid_data      (skid_data)
            );
        end else begin : g_no_skid
            assign in_ready       = ~stall & (~valid_q | out_ready);
            assign main_load_in   = in_fire;
            assign main_load_skid = 1'b0;
            assign main_clear     = out_fire & ~in_fire;
            assign skid_ctrl      = '0;
            assign skid_data      = '0;
        end
    endgenerate

    // rst > flush > stall > handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            data_q  <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            if (ZERO_DATA_ON_FLUSH != 0) begin
                data_q <= '0;
            end
        end else if (!stall) begin
            if (main_load_in) begin
                valid_q <= 1'b1;
                ctrl_q  <= in_ctrl;
                data_q  <= in_data;
            end else if (main_load_skid) begin
                valid_q <= 1'b1;
                ctrl_q  <= skid_ctrl;
                data_q  <= skid_data;
            end else if (main_clear) begin
                // bubble: ctrl zeroed so nothing downstream writes state
                valid_q <= 1'b0;
                ctrl_q  <= '0;
            end
        end
    end

    assign out_valid = valid_q;
    assign out_ctrl  = ctrl_q;
    assign out_data  = data_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Drives a plain (SKID=0, data zeroed on flush) and a skid (SKID=1, data kept
// on flush) stage with shared stimulus and checks each against its own FIFO scoreboard.
module tb_pipe_stage_reg;
    localparam int unsigned CW = 16;
    localparam int unsigned DW = 165;

    typedef struct packed {
        logic [CW-1:0] ctrl;
        logic [DW-1:0] data;
    } entry_t;

    logic          clk = 1'b0;
    logic          rst, in_valid, out_ready, stall, flush;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;

    logic          u0_in_ready, u0_out_valid, u1_in_ready, u1_out_valid;
    logic [CW-1:0] u0_out_ctrl, u1_out_ctrl;
    logic [DW-1:0] u0_out_data, u1_out_data;

    entry_t q0[$];
    entry_t q1[$];
    entry_t e;
    logic   mon_en = 1'b0;
    int     n_compared = 0;
    int     n_mismatched = 0;
    logic [DW-1:0] d11;

    always #5 clk = ~clk;

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(0), .ZERO_DATA_ON_FLUSH(1)) u0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(u0_in_ready),
        .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(u0_out_valid),
        .out_ready(out_ready), .out_ctrl(u0_out_ctrl), .out_data(u0_out_data),
        .stall(stall), .flush(flush)
    );

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1), .ZERO_DATA_ON_FLUSH(0)) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(u1_in_ready),
        .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(u1_out_valid),
        .out_ready(out_ready), .out_ctrl(u1_out_ctrl), .out_data(u1_out_data),
        .stall(stall), .flush(flush)
    );

    task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_data();
        logic [191:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return r[DW-1:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d);
        in_valid = v;
        in_ctrl  = c;
        in_data  = d;
    endtask

    // Scoreboard: push on accepted input, pop and compare on consumed output.
    always @(negedge clk) begin
        if (mon_en) begin
            check("u0_valid_vs_sb", 192'(u0_out_valid), 192'(q0.size() != 0));
            check("u1_valid_vs_sb", 192'(u1_out_valid), 192'(q1.size() != 0));
            check("u1_ready_vs_sb", 192'(u1_in_ready), 192'(q1.size() != 2));
            if (u0_out_valid && out_ready && !stall && !flush && !rst && q0.size() != 0) begin
                e = q0.pop_front();
                check("u0_out_ctrl", 192'(u0_out_ctrl), 192'(e.ctrl));
                check("u0_out_data", 192'(u0_out_data), 192'(e.data));
            end
            if (u1_out_valid && out_ready && !stall && !flush && !rst && q1.size() != 0) begin
                e = q1.pop_front();
                check("u1_out_ctrl", 192'(u1_out_ctrl), 192'(e.ctrl));
                check("u1_out_data", 192'(u1_out_data), 192'(e.data));
            end
            if (flush || rst) begin
                q0.delete();
                q1.delete();
            end else begin
                if (in_valid && u0_in_ready && !stall) q0.push_back({in_ctrl, in_data});
                if (in_valid && u1_in_ready && !stall) q1.push_back({in_ctrl, in_data});
            end
        end
    end

    initial begin
        rst = 1'b1; out_ready = 1'b1; stall = 1'b0; flush = 1'b0;
        drive(1'b1, 16'hFFFF, {DW{1'b1}});
        tick();
        check("rst_u1_ready_during", 192'(u1_in_ready), 192'(0));
        tick();
        check("rst_u0_valid", 192'(u0_out_valid), 192'(0));
        check("rst_u0_ctrl", 192'(u0_out_ctrl), 192'(0));
        check("rst_u0_data", 192'(u0_out_data), 192'(0));
        check("rst_u1_valid", 192'(u1_out_valid), 192'(0));
        check("rst_u1_ctrl", 192'(u1_out_ctrl), 192'(0));
        check("rst_u1_data", 192'(u1_out_data), 192'(0));
        check("rst_u1_ready_still", 192'(u1_in_ready), 192'(0));
        rst = 1'b0;
        drive(1'b0, '0, '0);
        tick();
        check("rst_u1_ready_after", 192'(u1_in_ready), 192'(1));
        check("rst_u0_ready_after", 192'(u0_in_ready), 192'(1));
        mon_en = 1'b1;

        // Streaming with no backpressure
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, CW'(i), rand_data());
            tick();
            check("stream_u0_valid", 192'(u0_out_valid), 192'(1));
            check("stream_u0_ctrl", 192'(u0_out_ctrl), 192'(i));
            check("stream_u1_valid", 192'(u1_out_valid), 192'(1));
            check("stream_u1_ctrl", 192'(u1_out_ctrl), 192'(i));
        end
        drive(1'b0, '0, '0);
        tick();
        check("stream_u0_bubble", 192'(u0_out_valid), 192'(0));
        check("stream_u1_bubble", 192'(u1_out_valid), 192'(0));

        // Backpressure: u1 absorbs a second entry, u0 cannot
        out_ready = 1'b0;
        drive(1'b1, 16'd5, rand_data());
        tick();
        check("bp_u0_ctrl5", 192'(u0_out_ctrl), 192'(5));
        check("bp_u1_ctrl5", 192'(u1_out_ctrl), 192'(5));
        drive(1'b1, 16'd6, rand_data());
        tick();
        check("bp_u1_ready_two", 192'(u1_in_ready), 192'(0));
        check("bp_u0_ready_full", 192'(u0_in_ready), 192'(0));
        check("bp_u1_hold5", 192'(u1_out_ctrl), 192'(5));
        drive(1'b0, '0, '0);
        out_ready = 1'b1;
        tick();
        check("bp_u1_ctrl6", 192'(u1_out_ctrl), 192'(6));
        check("bp_u1_ready_one", 192'(u1_in_ready), 192'(1));
        check("bp_u0_drained", 192'(u0_out_valid), 192'(0));
        tick();
        check("bp_u1_drained", 192'(u1_out_valid), 192'(0));

        // Flush while u1 holds two entries
        out_ready = 1'b0;
        d11 = rand_data();
        drive(1'b1, 16'h11, d11);
        tick();
        drive(1'b1, 16'h12, rand_data());
        tick();
        check("fl_u1_two", 192'(u1_in_ready), 192'(0));
        drive(1'b1, 16'd7, rand_data());
        flush = 1'b1;
        tick();
        check("fl_u0_valid", 192'(u0_out_valid), 192'(0));
        check("fl_u0_ctrl", 192'(u0_out_ctrl), 192'(0));
        check("fl_u0_data_zero", 192'(u0_out_data), 192'(0));
        check("fl_u1_valid", 192'(u1_out_valid), 192'(0));
        check("fl_u1_ctrl", 192'(u1_out_ctrl), 192'(0));
        check("fl_u1_data_held", 192'(u1_out_data), 192'(d11));
        check("fl_u1_ready_empty", 192'(u1_in_ready), 192'(1));
        flush = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, '0, '0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("fl_u0_no7", 192'(u0_out_valid), 192'(0));
            check("fl_u1_no7", 192'(u1_out_valid), 192'(0));
        end

        // Stall holds everything
        drive(1'b1, 16'd9, rand_data());
        tick();
        stall = 1'b1;
        drive(1'b1, 16'h0A, rand_data());
        for (int i = 0; i < 3; i++) begin
            tick();
            check("st_u0_ctrl9", 192'(u0_out_ctrl), 192'(9));
            check("st_u1_ctrl9", 192'(u1_out_ctrl), 192'(9));
            check("st_u0_valid", 192'(u0_out_valid), 192'(1));
            check("st_u1_valid", 192'(u1_out_valid), 192'(1));
            check("st_u0_ready", 192'(u0_in_ready), 192'(0));
        end
        stall = 1'b0;
        drive(1'b0, '0, '0);
        tick();
        check("st_u0_once", 192'(u0_out_valid), 192'(0));
        check("st_u1_once", 192'(u1_out_valid), 192'(0));

        // Stall and flush together: flush wins
        drive(1'b1, 16'h0B, rand_data());
        tick();
        check("sf_u0_loaded", 192'(u0_out_valid), 192'(1));
        stall = 1'b1;
        flush = 1'b1;
        drive(1'b1, 16'h0C, rand_data());
        tick();
        check("sf_u0_valid", 192'(u0_out_valid), 192'(0));
        check("sf_u1_valid", 192'(u1_out_valid), 192'(0));
        check("sf_u1_ctrl", 192'(u1_out_ctrl), 192'(0));
        stall = 1'b0;
        flush = 1'b0;
        drive(1'b0, '0, '0);
        tick();

        // Randomised traffic against the scoreboards
        for (int i = 0; i < 10000; i++) begin
            drive($urandom_range(0, 9) < 7, CW'($urandom()), rand_data());
            out_ready = $urandom_range(0, 9) < 6;
            stall     = $urandom_range(0, 9) == 0;
            flush     = $urandom_range(0, 99) < 3;
            tick();
        end
        drive(1'b0, '0, '0);
        out_ready = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("end_q0_empty", 192'(q0.size()), 192'(0));
        check("end_q1_empty", 192'(q1.size()), 192'(0));
        check("end_u0_idle", 192'(u0_out_valid), 192'(0));
        check("end_u1_idle", 192'(u1_out_valid), 192'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule
